// File: rtl/intr_sched_pkg.sv
// Shared constants and types for the machine-mode interrupt scheduler.
// Holds mcause encodings, MIP bit positions and the scheduler state enum.
// Pure declarations; no logic, no latency, no backpressure.
package intr_sched_pkg;

  // MIP/MIE bit positions; the exception code equals the bit position.
  localparam int MIP_MSIP_BIT = 3;
  localparam int MIP_MTIP_BIT = 7;
  localparam int MIP_MEIP_BIT = 11;

  // mcause values for a 64-bit machine, interrupt bit set.
  localparam logic [63:0] MACHINE_SOFTWARE_INTERRUPT = 64'h8000_0000_0000_0003;
  localparam logic [63:0] MACHINE_TIMER_INTERRUPT    = 64'h8000_0000_0000_0007;
  localparam logic [63:0] MACHINE_EXTERNAL_INTERRUPT = 64'h8000_0000_0000_000B;

  // Low-order exception codes reused for any XLEN.
  localparam logic [3:0] CODE_MSI = MACHINE_SOFTWARE_INTERRUPT[3:0];
  localparam logic [3:0] CODE_MTI = MACHINE_TIMER_INTERRUPT[3:0];
  localparam logic [3:0] CODE_MEI = MACHINE_EXTERNAL_INTERRUPT[3:0];

  typedef enum logic [1:0] {
    IS_IDLE  = 2'd0,
    IS_OFFER = 2'd1,
    IS_SLEEP = 2'd2
  } IntrSchedState;

  // Fixed priority MEI > MSI > MTI; caller guarantees at least one bit set.
  function automatic logic [3:0] pick_code(input logic mei, input logic msi);
    logic [3:0] code;
    code = CODE_MTI;
    if (msi) code = CODE_MSI;
    if (mei) code = CODE_MEI;
    return code;
  endfunction

endpackage

// File: rtl/intr_sched_sync_ff.sv
// Flop-chain synchronizer for one asynchronous level signal.
// Latency: STAGES clock cycles from input change to output change.
// No handshake; the level is simply resampled every cycle.
module sync_ff #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] chain_q;

  // Shift the async level through the chain; the first flop may go metastable.
  always_ff @(posedge clk) begin
    if (rst) chain_q <= '0;
    else     chain_q <= {chain_q[STAGES-2:0], d_i};
  end

  assign q_o = chain_q[STAGES-1];

endmodule

// File: rtl/intr_sched.sv
// Machine-mode interrupt scheduler: masks MIP with mie, picks by fixed priority, offers via valid/ack, sequences WFI sleep.
// Latency: pending source to intr_valid one cycle (registered state); MEIP adds SYNC_STAGES cycles.
// Offer holds until ack, source drop/mask or mstatus.MIE clear; build with INTR_SCHED_MEIP_EN to include external interrupts.
module intr_sched
  import intr_sched_pkg::*;
#(
  parameter int XLEN          = 64,
  parameter int SYNC_STAGES   = 2,
  parameter int SLEEP_TIMEOUT = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            msip,
  input  logic            mtip,
  input  logic            meip_async,
  input  logic [XLEN-1:0] mie_csr,
  input  logic            mstatus_mie,
  input  logic            can_intr,
  input  logic            wfi_retire,
  output logic            intr_valid,
  output logic [XLEN-1:0] intr_cause,
  input  logic            intr_ack,
  output logic [XLEN-1:0] mip_view,
  output logic            stall_fetch,
  output logic            wake
);

  // Counter must hold SLEEP_TIMEOUT; keep at least one bit when timeout is off.
  localparam int CW = (SLEEP_TIMEOUT > 0) ? $clog2(SLEEP_TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CNT_MAX  = '1;
  localparam logic [CW-1:0] CNT_LAST = (SLEEP_TIMEOUT > 0) ? CW'(SLEEP_TIMEOUT - 1) : '0;
  localparam bit            TO_EN    = (SLEEP_TIMEOUT > 0);

  IntrSchedState   state_q, state_d;
  logic [XLEN-1:0] cause_q, cause_d;
  logic [3:0]      idx_q, idx_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            wake_q, wake_d;

  logic            meip_sync;
  logic [XLEN-1:0] pend;
  logic            pend_any;
  logic [3:0]      sel_code;
  logic [XLEN-1:0] sel_cause;
  logic            timeout_hit;

`ifdef INTR_SCHED_MEIP_EN
  sync_ff #(
    .STAGES (SYNC_STAGES)
  ) u_meip_sync (
    .clk (clk),
    .rst (rst),
    .d_i (meip_async),
    .q_o (meip_sync)
  );
`else
  // External interrupts are not part of this build; the port is kept for a stable interface.
  logic unused_meip;
  assign unused_meip = meip_async;
  assign meip_sync   = 1'b0;
`endif

  // MIP read image: only the three machine-level interrupt bits are ever set.
  always_comb begin
    mip_view               = '0;
    mip_view[MIP_MSIP_BIT] = msip;
    mip_view[MIP_MTIP_BIT] = mtip;
    mip_view[MIP_MEIP_BIT] = meip_sync;
  end

  assign pend     = mip_view & mie_csr;
  assign pend_any = pend[MIP_MEIP_BIT] | pend[MIP_MSIP_BIT] | pend[MIP_MTIP_BIT];
  assign sel_code = pick_code(pend[MIP_MEIP_BIT], pend[MIP_MSIP_BIT]);

  // mcause image for the winning source: interrupt bit plus the exception code.
  always_comb begin
    sel_cause            = '0;
    sel_cause[XLEN-1]    = 1'b1;
    sel_cause[3:0]       = sel_code;
  end

  assign timeout_hit = TO_EN && (cnt_q == CNT_LAST);

  // Next-state, latched cause and sleep counter; IDLE gives an offer priority over WFI.
  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    wake_d  = 1'b0;
    unique case (state_q)
      IS_IDLE: begin
        if (mstatus_mie && can_intr && pend_any) begin
          state_d = IS_OFFER;
          cause_d = sel_cause;
          idx_d   = sel_code;
        end else if (wfi_retire) begin
          state_d = IS_SLEEP;
          cnt_d   = '0;
        end
      end
      IS_OFFER: begin
        // Ack wins over a simultaneous drop; otherwise a dropped/masked source or cleared MIE withdraws.
        if (intr_ack || !pend[idx_q] || !mstatus_mie) begin
          state_d = IS_IDLE;
          cause_d = '0;
        end
      end
      IS_SLEEP: begin
        if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
        // Wake ignores mstatus.MIE: an enabled pending source always ends WFI.
        if (pend_any || timeout_hit) begin
          state_d = IS_IDLE;
          wake_d  = 1'b1;
        end
      end
      default: begin
        state_d = IS_IDLE;
        cause_d = '0;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IS_IDLE;
      cause_q <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      wake_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      wake_q  <= wake_d;
    end
  end

  assign intr_valid  = (state_q == IS_OFFER);
  assign intr_cause  = cause_q;
  assign stall_fetch = (state_q == IS_SLEEP);
  assign wake        = wake_q;

endmodule
